cordic_iter_seq: RTL and testbench
==================================

Name: cordic_iter_seq

Overview:
Parametrised CORDIC iteration sequencer, successor to the fixed 6-bit mode counter. Accepts a start request and coordinate-system select, then emits one shift index per advance cycle to the CORDIC datapath. Inserts hyperbolic repeat iterations (4, 13, 40, ...). Reports first/last/repeat flags and a one-cycle done pulse.

Parameters:
ITER_W, 6, width of iteration index output.
N_ITER, 16, last emitted index is N_ITER-1; legal range 2..2**ITER_W.
HYP_REP_EN_P, 1, 1 = insert hyperbolic repeats; 0 = hyperbolic runs like circular but starts at index 1.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous, active-high reset.
start  in  1  request a run; sampled only in IDLE or DONE.
coordinate_system_in  in  2  00 circular, 01 linear, 10 hyperbolic, 11 reserved.
step_en  in  1  datapath ready; index advances only when high.
iter_idx  out  ITER_W  current shift index.
iter_vld  out  1  iter_idx valid this cycle.
iter_rep  out  1  current index is the repeated copy.
iter_first  out  1  first step of the run.
iter_last  out  1  final step of the run.
busy  out  1  high in RUN.
done  out  1  one-cycle pulse after the last step is consumed.
cfg_err  out  1  one-cycle pulse when start is raised with mode 11.
mode_q  out  2  mode latched at start.

Behaviour:
- Reset: state IDLE; iter_idx=0, all flags 0, mode_q=00, repeat-point register=4.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1 and mode!=11:
  - Latch mode_q and go to RUN next cycle.
  - iter_idx = 1 if hyperbolic, else 0.
  - iter_first=1, iter_vld=1.
- IDLE/DONE with start=1 and mode=11: stay in state, pulse cfg_err, no run.
- RUN: iter_vld=1 every cycle. A step is consumed when iter_vld && step_en. With step_en=0, all outputs hold (stall).
- On a consumed step:
  - If this is the last step: go to DONE, drop iter_vld, pulse done next cycle.
  - Else, hyperbolic with HYP_REP_EN_P=1, iter_idx==rep_pt and iter_rep=0: hold iter_idx, set iter_rep=1, set rep_pt=3*rep_pt+1, computed at ITER_W+2 bits and saturated to all-ones.
  - Else: iter_idx+1, iter_rep=0.
- Last step:
  - iter_idx==N_ITER-1, and either not a repeat point or iter_rep=1.
  - iter_last is asserted combinationally during that step.
- iter_first deasserts after the first consumed step.
- DONE lasts one cycle unless start is re-raised; it then returns to IDLE. Back-to-back start from DONE is legal (zero-bubble restart).
- start while busy is ignored; coordinate_system_in changes mid-run are ignored (mode_q used).
- rst mid-run: next cycle IDLE, no done pulse.
- Index never wraps; counter width ITER_W suffices by parameter range.

Optional Feature:
- Macro: CORDIC_SEQ_STATS_EN.
- Defined:
  - Adds output run_cycles[ITER_W+3:0], which counts clock cycles in RUN including stalls.
  - Cleared at run start, frozen at DONE, reset to 0.
  - Adds output rep_count[3:0], the number of repeats inserted in the last run.
- Undefined: both ports and all related logic are absent.

Decomposition:
- Package cordic_pkg:
  - typedef enum logic[1:0] coord_sys_e {CIRC=2'b00, LIN=2'b01, HYP=2'b10, RSVD=2'b11}.
  - typedef enum seq_state_e {IDLE, RUN, DONE}.
  - Localparam HYP_FIRST_REP=4.
- One sub-module, cordic_rep_gen: holds rep_pt, with load/advance inputs, and outputs the hit compare against iter_idx.

Test Plan:
- Circular, N_ITER=16, step_en=1, start pulse at t=10: idx 0..15 over 16 cycles, iter_first at idx 0, iter_last at idx 15, done pulse next cycle, iter_rep never set.
- Hyperbolic, N_ITER=16: sequence 1,2,3,4,4r,5..13,13r,14,15 (17 valid cycles); iter_rep high on the second 4 and second 13; done after 15.
- Linear with step_en toggling 1,0 alternately: idx 0..15, each value held during stall cycles, 31 RUN cycles total; with CORDIC_SEQ_STATS_EN, run_cycles=31.
- Start with coordinate_system_in=2'b11 from reset: cfg_err single pulse, busy stays 0, iter_vld stays 0.
- Circular run; assert rst at idx 7 for one cycle: next cycle all outputs at reset values, no done; a new start then begins at idx 0.
- start held high through run and DONE: mid-run starts ignored, immediate restart from DONE, mode_q reflects mode sampled at restart.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC iteration sequencer.
// Optional build macro used by the sequencer: CORDIC_SEQ_STATS_EN.
package cordic_pkg;

  typedef enum logic [1:0] {
    CIRC = 2'b00,
    LIN  = 2'b01,
    HYP  = 2'b10,
    RSVD = 2'b11
  } coord_sys_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  // First hyperbolic index that is executed twice; later ones follow k -> 3k+1.
  localparam int HYP_FIRST_REP = 4;

endpackage

// File: rtl/cordic_rep_gen.sv
// Hyperbolic repeat-point tracker: holds the next index that must be issued
// twice (4, 13, 40, ...) and flags when the current index hits it.
module cordic_rep_gen
  import cordic_pkg::*;
#(
  parameter int ITER_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              adv_i,
  input  logic [ITER_W-1:0] idx_i,
  output logic              hit_o
);

  logic [ITER_W-1:0] rep_pt_q, rep_pt_d;
  logic [ITER_W+1:0] next_w;

  // 3k+1 always fits in two extra bits; anything beyond the index range
  // saturates so the point simply becomes unreachable or the top index.
  assign next_w = ({2'b00, rep_pt_q} * (ITER_W+2)'(3)) + (ITER_W+2)'(1);

  // Next repeat point: reload on run start, step after each inserted repeat.
  always_comb begin
    rep_pt_d = rep_pt_q;
    if (load_i) begin
      rep_pt_d = ITER_W'(HYP_FIRST_REP);
    end else if (adv_i) begin
      if (|next_w[ITER_W+1:ITER_W]) rep_pt_d = {ITER_W{1'b1}};
      else                          rep_pt_d = next_w[ITER_W-1:0];
    end
  end

  // Repeat-point register.
  always_ff @(posedge clk) begin
    if (rst) rep_pt_q <= ITER_W'(HYP_FIRST_REP);
    else     rep_pt_q <= rep_pt_d;
  end

  assign hit_o = (idx_i == rep_pt_q);

endmodule

// File: rtl/cordic_iter_seq.sv
// CORDIC iteration sequencer: issues one shift index per consumed step,
// inserting hyperbolic repeat iterations, with first/last/repeat flags
// and a one-cycle done pulse.
// Optional build macro: CORDIC_SEQ_STATS_EN adds run_cycles / rep_count.
//
// Handshake: iter_vld is high for every RUN cycle; a step is consumed on a
// rising clock edge where iter_vld && step_en. Without step_en all outputs
// hold, so the datapath may stall for any number of cycles.
module cordic_iter_seq
  import cordic_pkg::*;
#(
  parameter int ITER_W       = 6,
  parameter int N_ITER       = 16,
  parameter bit HYP_REP_EN_P = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        coordinate_system_in,
  input  logic              step_en,
  output logic [ITER_W-1:0] iter_idx,
  output logic              iter_vld,
  output logic              iter_rep,
  output logic              iter_first,
  output logic              iter_last,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic [1:0]        mode_q,
`ifdef CORDIC_SEQ_STATS_EN
  output logic [ITER_W+3:0] run_cycles,
  output logic [3:0]        rep_count,
`endif
  output logic [1:0]        state_dbg_o
);

  localparam logic [ITER_W-1:0] LAST_IDX = ITER_W'(N_ITER - 1);

  seq_state_e        state_q, state_d;
  logic [ITER_W-1:0] idx_q, idx_d;
  logic              rep_q, rep_d;
  logic              first_q, first_d;
  logic              done_q, done_d;
  logic              cfg_err_q, cfg_err_d;
  logic [1:0]        mode_d;
  logic              rep_hit, rep_load, rep_adv;
  logic              at_rep, last_step;

  cordic_rep_gen #(.ITER_W(ITER_W)) u_rep_gen (
    .clk    (clk),
    .rst    (rst),
    .load_i (rep_load),
    .adv_i  (rep_adv),
    .idx_i  (idx_q),
    .hit_o  (rep_hit)
  );

  // The current index is a repeat point only for hyperbolic runs with repeats on.
  assign at_rep    = HYP_REP_EN_P && (mode_q == HYP) && rep_hit;
  assign last_step = (state_q == RUN) && (idx_q == LAST_IDX) && (!at_rep || rep_q);

  // Sequencer next-state: start/config check when idle, index advance in RUN.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rep_d     = rep_q;
    first_d   = first_q;
    mode_d    = mode_q;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;
    rep_load  = 1'b0;
    rep_adv   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        // DONE is a single cycle unless a restart is taken.
        state_d = IDLE;
        if (start) begin
          if (coordinate_system_in == RSVD) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d  = RUN;
            mode_d   = coordinate_system_in;
            idx_d    = (coordinate_system_in == HYP) ? ITER_W'(1) : '0;
            rep_d    = 1'b0;
            first_d  = 1'b1;
            rep_load = 1'b1;
          end
        end
      end
      RUN: begin
        if (step_en) begin
          first_d = 1'b0;
          if (last_step) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (at_rep && !rep_q) begin
            rep_d   = 1'b1;
            rep_adv = 1'b1;
          end else begin
            idx_d = idx_q + ITER_W'(1);
            rep_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      rep_q     <= 1'b0;
      first_q   <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      mode_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rep_q     <= rep_d;
      first_q   <= first_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
      mode_q    <= mode_d;
    end
  end

`ifdef CORDIC_SEQ_STATS_EN
  logic [ITER_W+3:0] run_cyc_q;
  logic [3:0]        rep_cnt_q;

  // Run statistics: cleared at run start, counting only while in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cyc_q <= '0;
      rep_cnt_q <= '0;
    end else if (rep_load) begin
      run_cyc_q <= '0;
      rep_cnt_q <= '0;
    end else begin
      if (state_q == RUN) run_cyc_q <= run_cyc_q + (ITER_W+4)'(1);
      if (rep_adv)        rep_cnt_q <= rep_cnt_q + 4'd1;
    end
  end

  assign run_cycles = run_cyc_q;
  assign rep_count  = rep_cnt_q;
`endif

  assign iter_idx    = idx_q;
  assign iter_vld    = (state_q == RUN);
  assign iter_rep    = rep_q;
  assign iter_first  = first_q;
  assign iter_last   = last_step;
  assign busy        = (state_q == RUN);
  assign done        = done_q;
  assign cfg_err     = cfg_err_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_cordic_iter_seq.sv
// Directed bench for cordic_iter_seq: a sequence model builds the list of
// (index, repeat, first, last) steps a run must produce, and a negedge
// monitor walks the DUT outputs through that list.
module tb_cordic_iter_seq;

  localparam int ITER_W = 6;
  localparam int N_ITER = 16;
  localparam int QW     = ITER_W + 3;  // {first, last, rep, idx}

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [1:0]        coordinate_system_in;
  logic              step_en;
  logic [ITER_W-1:0] iter_idx;
  logic              iter_vld, iter_rep, iter_first, iter_last;
  logic              busy, done, cfg_err;
  logic [1:0]        mode_q;
  logic [1:0]        state_dbg;
`ifdef CORDIC_SEQ_STATS_EN
  logic [ITER_W+3:0] run_cycles;
  logic [3:0]        rep_count;
`endif

  cordic_iter_seq #(.ITER_W(ITER_W), .N_ITER(N_ITER), .HYP_REP_EN_P(1'b1)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .coordinate_system_in (coordinate_system_in),
    .step_en              (step_en),
    .iter_idx             (iter_idx),
    .iter_vld             (iter_vld),
    .iter_rep             (iter_rep),
    .iter_first           (iter_first),
    .iter_last            (iter_last),
    .busy                 (busy),
    .done                 (done),
    .cfg_err              (cfg_err),
    .mode_q               (mode_q),
`ifdef CORDIC_SEQ_STATS_EN
    .run_cycles           (run_cycles),
    .rep_count            (rep_count),
`endif
    .state_dbg_o          (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [QW-1:0] exp_q[$];
  logic [QW-1:0] gen_q[$];
  logic [1:0]  exp_mode = 2'b00;
  bit          done_pend = 1'b0;
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Sequence model: every index from the start index to N_ITER-1, with
  // hyperbolic repeat points 4, 13, 40, ... issued twice.
  function automatic void gen_seq(input logic [1:0] m);
    int idxs[$];
    int reps[$];
    int rp = 4;
    int lo = (m == 2'b10) ? 1 : 0;
    gen_q.delete();
    for (int i = lo; i < N_ITER; i++) begin
      idxs.push_back(i); reps.push_back(0);
      if (m == 2'b10 && i == rp) begin
        idxs.push_back(i); reps.push_back(1);
        rp = (3 * rp + 1 > 63) ? 63 : 3 * rp + 1;
      end
    end
    for (int j = 0; j < idxs.size(); j++) begin
      logic [QW-1:0] e;
      e[ITER_W-1:0] = idxs[j][ITER_W-1:0];
      e[ITER_W]     = reps[j][0];
      e[ITER_W+1]   = (j == idxs.size() - 1);
      e[ITER_W+2]   = (j == 0);
      gen_q.push_back(e);
    end
  endfunction

  // Compare process: each negedge, check against the head expected step.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [QW-1:0] it;
      it = exp_q[0];
      chk("iter_vld",   iter_vld,   1);
      chk("iter_idx",   iter_idx,   it[ITER_W-1:0]);
      chk("iter_rep",   iter_rep,   it[ITER_W]);
      chk("iter_last",  iter_last,  it[ITER_W+1]);
      chk("iter_first", iter_first, it[ITER_W+2]);
      chk("busy_run",   busy,       1);
      chk("done_run",   done,       0);
      chk("mode_q",     mode_q,     exp_mode);
      if (step_en) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) done_pend = 1'b1;
      end
    end else if (done_pend) begin
      chk("done_pulse", done,     1);
      chk("vld_done",   iter_vld, 0);
      chk("busy_done",  busy,     0);
      done_pend = 1'b0;
    end else if (mon_en) begin
      chk("vld_idle",  iter_vld, 0);
      chk("busy_idle", busy,     0);
      chk("done_idle", done,     0);
    end
  end

  // Raise start for one edge and arm the expected sequence once RUN begins.
  task automatic launch(input logic [1:0] m, input bit keep);
    @(posedge clk); #1;
    start = 1'b1;
    coordinate_system_in = m;
    @(posedge clk); #1;
    if (!keep) start = 1'b0;
    gen_seq(m);
    exp_mode = m;
    exp_q = gen_q;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic idle_gap();
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; coordinate_system_in = 2'b00; step_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_idx",   iter_idx,   0);
    chk("rst_vld",   iter_vld,   0);
    chk("rst_flags", {iter_rep, iter_first, iter_last, busy, done, cfg_err}, 0);
    chk("rst_mode",  mode_q,     0);
    chk("rst_state", state_dbg,  0);
    @(posedge clk); #1 rst = 1'b0;
    mon_en = 1'b1;

    // Pin the model against hand-derived sequences.
    gen_seq(2'b00);
    chk("model_circ_len",  gen_q.size(), 16);
    chk("model_circ_last", gen_q[15], {3'b010, 6'd15});
    gen_seq(2'b10);
    chk("model_hyp_len",   gen_q.size(), 17);
    chk("model_hyp_first", gen_q[0],  {3'b100, 6'd1});
    chk("model_hyp_rep4",  gen_q[4],  {3'b001, 6'd4});
    chk("model_hyp_rep13", gen_q[14], {3'b001, 6'd13});
    chk("model_hyp_last",  gen_q[16], {3'b010, 6'd15});

    // Circular, full speed.
    step_en = 1'b1;
    launch(2'b00, 1'b0);
    wait_drain(40);
    idle_gap();

    // Hyperbolic with repeats.
    launch(2'b10, 1'b0);
    wait_drain(40);
    idle_gap();
`ifdef CORDIC_SEQ_STATS_EN
    chk("hyp_run_cycles", run_cycles, 17);
    chk("hyp_rep_count",  rep_count,  2);
`endif

    // Linear with alternating stalls.
    launch(2'b01, 1'b0);
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) begin
      @(posedge clk); #1 step_en = ~step_en;
    end
    chk("lin_drained", exp_q.size(), 0);
    step_en = 1'b1;
    idle_gap();
`ifdef CORDIC_SEQ_STATS_EN
    chk("lin_run_cycles", run_cycles, 31);
    chk("lin_rep_count",  rep_count,  0);
`endif

    // Reserved mode: single cfg_err pulse, no run.
    @(posedge clk); #1 start = 1'b1; coordinate_system_in = 2'b11;
    @(negedge clk);
    chk("cfg_err_pre", cfg_err, 0);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("cfg_err_pulse", cfg_err, 1);
    chk("cfg_busy",      busy,    0);
    @(negedge clk);
    chk("cfg_err_clear", cfg_err, 0);
    chk("cfg_vld",       iter_vld, 0);
    idle_gap();

    // Reset in the middle of a circular run, at index 7.
    launch(2'b00, 1'b0);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1; step_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; step_en = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("mrst_idx",   iter_idx,   0);
    chk("mrst_first", iter_first, 0);
    chk("mrst_mode",  mode_q,     0);
    chk("mrst_done",  done,       0);
    idle_gap();
    launch(2'b00, 1'b0);
    wait_drain(40);
    idle_gap();

    // Start held through the run; mode changes mid-run, restart from DONE.
    launch(2'b00, 1'b1);
    repeat (5) @(posedge clk);
    #1 coordinate_system_in = 2'b01;
    wait_drain(40);
    @(posedge clk);            // into DONE with start still high
    @(posedge clk); #1;        // restart edge
    start = 1'b0;
    gen_seq(2'b01);
    exp_mode = 2'b01;
    exp_q = gen_q;
    wait_drain(40);
    idle_gap();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
